// File: rtl/trap_pkg.sv
// trap_pkg: shared types and constants for the machine-mode trap sequencer.
//   state_e : sequencer states IDLE -> DRAIN -> COMMIT -> REDIRECT
//   kind_e  : latched request kind (exception, mret, interrupt)
//   IRQ_*   : mcause codes of the three M-mode interrupt sources
//   MTVEC_* : mtvec[1:0] mode encodings
package trap_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned CODE_W = 4;
   localparam int unsigned INFO_W = CODE_W + 1;

   localparam logic [CODE_W-1:0] IRQ_MSI = 4'd3;
   localparam logic [CODE_W-1:0] IRQ_MTI = 4'd7;
   localparam logic [CODE_W-1:0] IRQ_MEI = 4'd11;

   localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
   localparam logic [1:0] MTVEC_VECTORED = 2'd1;

   typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_e;
   typedef enum logic [1:0] {K_EXC, K_MRET, K_IRQ} kind_e;

endpackage

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: pipeline-control / CSR-file side bundle of the trap sequencer.
//   master : pipeline + CSR file (drives requests, interrupt lines, CSR values)
//   slave  : trap_ctrl (drives ack, hold, CSR strobes and the PC redirect)
interface trap_ctrl_if;
   import trap_pkg::*;

   logic              exc_req;
   logic [CODE_W-1:0] exc_code;
   logic [XLEN-1:0]   exc_pc;
   logic              mret_req;
   logic [XLEN-1:0]   irq_pc;
   logic              irq_msip;
   logic              irq_mtip;
   logic              irq_meip;
   logic              csr_mie;
   logic [XLEN-1:0]   csr_mie_reg;
   logic [XLEN-1:0]   csr_mtvec;
   logic [XLEN-1:0]   csr_mepc;
   logic              pipe_drained;

   logic              req_ack;
   logic              pipe_hold;
   logic              ctrl_trap;
   logic              ctrl_mret;
   logic [INFO_W-1:0] trap_info;
   logic [XLEN-1:0]   trap_pc;
   logic              redirect_valid;
   logic [XLEN-1:0]   redirect_pc;

   modport master (
      output exc_req, exc_code, exc_pc, mret_req, irq_pc,
             irq_msip, irq_mtip, irq_meip, csr_mie, csr_mie_reg,
             csr_mtvec, csr_mepc, pipe_drained,
      input  req_ack, pipe_hold, ctrl_trap, ctrl_mret, trap_info,
             trap_pc, redirect_valid, redirect_pc
   );

   modport slave (
      input  exc_req, exc_code, exc_pc, mret_req, irq_pc,
             irq_msip, irq_mtip, irq_meip, csr_mie, csr_mie_reg,
             csr_mtvec, csr_mepc, pipe_drained,
      output req_ack, pipe_hold, ctrl_trap, ctrl_mret, trap_info,
             trap_pc, redirect_valid, redirect_pc
   );

endinterface

// File: rtl/irq_prio.sv
// irq_prio: combinational qualified-interrupt priority encoder (MEI > MSI > MTI).
//   i_mie              : mstatus.MIE global enable
//   i_msip/i_mtip/i_meip : interrupt lines
//   i_msie/i_mtie/i_meie : per-source enables from mie
//   o_valid_c/o_code_c : highest-priority qualified source
//   o_qual_c           : per-source qualification {mei, mti, msi}
module irq_prio
   import trap_pkg::*;
(
   input  logic              i_mie,
   input  logic              i_msip,
   input  logic              i_mtip,
   input  logic              i_meip,
   input  logic              i_msie,
   input  logic              i_mtie,
   input  logic              i_meie,
   output logic              o_valid_c,
   output logic [CODE_W-1:0] o_code_c,
   output logic [2:0]        o_qual_c
);

   assign o_qual_c = {i_mie & i_meip & i_meie,
                      i_mie & i_mtip & i_mtie,
                      i_mie & i_msip & i_msie};

   always_comb begin
      o_valid_c = 1'b1;
      o_code_c  = '0;
      if (o_qual_c[2])      o_code_c = IRQ_MEI;
      else if (o_qual_c[0]) o_code_c = IRQ_MSI;
      else if (o_qual_c[1]) o_code_c = IRQ_MTI;
      else                  o_valid_c = 1'b0;
   end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: decides when the M-mode CSR file takes a trap or executes mret.
// Picks a source in IDLE, holds the pipeline until it drains, pulses the CSR
// trap strobe for one cycle, then issues one PC redirect (mtvec or mepc).
//   ctrl_clk   : clock
//   ctrl_reset : synchronous active-high reset
//   bus        : trap_ctrl_if.slave (requests, interrupt lines, CSRs in;
//                ack, hold, trap strobes, redirect out)
// Optional: TRAP_CTRL_VECTORED_EN enables vectored interrupt redirects.
module trap_ctrl
   import trap_pkg::*;
(
   input  logic        ctrl_clk,
   input  logic        ctrl_reset,
   trap_ctrl_if.slave  bus
);

   state_e            r_state;
   kind_e             r_kind;
   logic [CODE_W-1:0] r_code;
   logic [XLEN-1:0]   r_pc;

   logic              r_req_ack;
   logic              r_pipe_hold;
   logic              r_ctrl_trap;
   logic              r_ctrl_mret;
   logic [INFO_W-1:0] r_trap_info;
   logic [XLEN-1:0]   r_trap_pc;
   logic              r_redirect_valid;
   logic [XLEN-1:0]   r_redirect_pc;

   logic              w_irq_valid;
   logic [CODE_W-1:0] w_irq_code;
   logic [2:0]        w_irq_qual;
   logic              w_lat_qual;
   logic [XLEN-1:0]   w_base;
   logic [XLEN-1:0]   w_target;
   logic              w_unused;

   irq_prio u_irq_prio (
      .i_mie     (bus.csr_mie),
      .i_msip    (bus.irq_msip),
      .i_mtip    (bus.irq_mtip),
      .i_meip    (bus.irq_meip),
      .i_msie    (bus.csr_mie_reg[IRQ_MSI]),
      .i_mtie    (bus.csr_mie_reg[IRQ_MTI]),
      .i_meie    (bus.csr_mie_reg[IRQ_MEI]),
      .o_valid_c (w_irq_valid),
      .o_code_c  (w_irq_code),
      .o_qual_c  (w_irq_qual)
   );

   // Is the latched interrupt source still qualified (spurious-abort check)
   always_comb begin
      w_lat_qual = 1'b0;
      case (r_code)
         IRQ_MSI: w_lat_qual = w_irq_qual[0];
         IRQ_MTI: w_lat_qual = w_irq_qual[1];
         IRQ_MEI: w_lat_qual = w_irq_qual[2];
         default: w_lat_qual = 1'b0;
      endcase
   end

   // Redirect target; mtvec modes 2/3 fall through to direct
   assign w_base = {bus.csr_mtvec[XLEN-1:2], 2'b00};

   always_comb begin
      w_target = w_base;
      if (r_kind == K_MRET) begin
         w_target = bus.csr_mepc;
      end
`ifdef TRAP_CTRL_VECTORED_EN
      else if (r_kind == K_IRQ && bus.csr_mtvec[1:0] == MTVEC_VECTORED) begin
         w_target = w_base + XLEN'({r_code, 2'b00});
      end
`endif
   end

`ifdef TRAP_CTRL_VECTORED_EN
   assign w_unused = ^{bus.csr_mie_reg[31:12], bus.csr_mie_reg[10:8],
                       bus.csr_mie_reg[6:4], bus.csr_mie_reg[2:0]};
`else
   assign w_unused = ^{bus.csr_mie_reg[31:12], bus.csr_mie_reg[10:8],
                       bus.csr_mie_reg[6:4], bus.csr_mie_reg[2:0],
                       bus.csr_mtvec[1:0]};
`endif

   // Sequencer; every output is registered and changes together with the state
   always_ff @(posedge ctrl_clk) begin
      if (ctrl_reset) begin
         r_state          <= IDLE;
         r_kind           <= K_EXC;
         r_code           <= '0;
         r_pc             <= '0;
         r_req_ack        <= 1'b0;
         r_pipe_hold      <= 1'b0;
         r_ctrl_trap      <= 1'b0;
         r_ctrl_mret      <= 1'b0;
         r_trap_info      <= '0;
         r_trap_pc        <= '0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
      end else begin
         r_req_ack        <= 1'b0;
         r_ctrl_trap      <= 1'b0;
         r_ctrl_mret      <= 1'b0;
         r_trap_info      <= '0;
         r_trap_pc        <= '0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
         case (r_state)
            IDLE: begin
               if (bus.exc_req || bus.mret_req || w_irq_valid) begin
                  r_state     <= DRAIN;
                  r_pipe_hold <= 1'b1;
               end
               if (bus.exc_req) begin
                  r_kind <= K_EXC;
                  r_code <= bus.exc_code;
                  r_pc   <= bus.exc_pc;
               end else if (bus.mret_req) begin
                  r_kind <= K_MRET;
                  r_code <= '0;
                  r_pc   <= '0;
               end else if (w_irq_valid) begin
                  r_kind <= K_IRQ;
                  r_code <= w_irq_code;
                  r_pc   <= bus.irq_pc;
               end
            end
            DRAIN: begin
               if (r_kind == K_IRQ && bus.exc_req) begin
                  // Exception belongs to an older instruction: it displaces the interrupt
                  r_kind <= K_EXC;
                  r_code <= bus.exc_code;
                  r_pc   <= bus.exc_pc;
               end else if (r_kind == K_IRQ && !w_lat_qual) begin
                  r_state     <= IDLE;
                  r_pipe_hold <= 1'b0;
               end else if (bus.pipe_drained) begin
                  r_state     <= COMMIT;
                  r_ctrl_trap <= 1'b1;
                  r_req_ack   <= (r_kind != K_IRQ);
                  if (r_kind == K_MRET) begin
                     r_ctrl_mret <= 1'b1;
                  end else begin
                     r_trap_info <= {r_kind == K_IRQ, r_code};
                     r_trap_pc   <= r_pc;
                  end
               end
            end
            COMMIT: begin
               r_state          <= REDIRECT;
               r_redirect_valid <= 1'b1;
               r_redirect_pc    <= w_target;
            end
            REDIRECT: begin
               r_state     <= IDLE;
               r_pipe_hold <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.req_ack        = r_req_ack;
   assign bus.pipe_hold      = r_pipe_hold;
   assign bus.ctrl_trap      = r_ctrl_trap;
   assign bus.ctrl_mret      = r_ctrl_mret;
   assign bus.trap_info      = r_trap_info;
   assign bus.trap_pc        = r_trap_pc;
   assign bus.redirect_valid = r_redirect_valid;
   assign bus.redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: self-checking bench for trap_ctrl (directed scenarios plus
// randomized requests checked against a transaction-level reference model).
module tb_trap_ctrl;

   logic ctrl_clk;
   logic ctrl_reset;
   int   checks;
   int   errors;

   trap_ctrl_if bus ();

   trap_ctrl dut (
      .ctrl_clk   (ctrl_clk),
      .ctrl_reset (ctrl_reset),
      .bus        (bus)
   );

   initial ctrl_clk = 1'b0;
   always #5 ctrl_clk = ~ctrl_clk;

   task automatic tick();
      @(posedge ctrl_clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.exc_req      = 1'b0;
      bus.exc_code     = '0;
      bus.exc_pc       = '0;
      bus.mret_req     = 1'b0;
      bus.irq_pc       = '0;
      bus.irq_msip     = 1'b0;
      bus.irq_mtip     = 1'b0;
      bus.irq_meip     = 1'b0;
      bus.csr_mie      = 1'b0;
      bus.csr_mie_reg  = '0;
      bus.csr_mtvec    = '0;
      bus.csr_mepc     = '0;
      bus.pipe_drained = 1'b0;
   endtask

   // Reference: redirect target from the architectural rules
   function automatic logic [31:0] ref_target(bit is_mret, bit is_irq, int code,
                                              logic [31:0] mtvec, logic [31:0] mepc);
      logic [31:0] base;
      if (is_mret) return mepc;
      base = mtvec - (mtvec % 4);
`ifdef TRAP_CTRL_VECTORED_EN
      if (is_irq && (mtvec % 4) == 1) return base + 32'(code * 4);
`endif
      return base;
   endfunction

   task automatic test_reset();
      logic [73:0] outs;
      ctrl_reset = 1'b1;
      bus.exc_req = 1'b1;
      bus.mret_req = 1'b1;
      bus.pipe_drained = 1'b1;
      tick();
      tick();
      outs = {bus.req_ack, bus.pipe_hold, bus.ctrl_trap, bus.ctrl_mret, bus.trap_info,
              bus.trap_pc, bus.redirect_valid, bus.redirect_pc};
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0", outs);
      end
      ctrl_reset = 1'b0;
      clear_inputs();
      tick();
   endtask

   task automatic test_exception();
      clear_inputs();
      bus.exc_req = 1'b1; bus.exc_code = 4'd2; bus.exc_pc = 32'h100;
      bus.csr_mtvec = 32'h8000; bus.pipe_drained = 1'b1;
      tick();
      checks++;
      if ({bus.pipe_hold, bus.ctrl_trap} !== 2'b10) begin
         errors++; $display("FAIL exc_cycle1: hold/trap got %b expected 10", {bus.pipe_hold, bus.ctrl_trap});
      end
      tick();
      checks++;
      if ({bus.ctrl_trap, bus.ctrl_mret, bus.req_ack} !== 3'b101) begin
         errors++; $display("FAIL exc_strobe: trap/mret/ack got %b expected 101", {bus.ctrl_trap, bus.ctrl_mret, bus.req_ack});
      end
      checks++;
      if (bus.trap_info !== 5'h02 || bus.trap_pc !== 32'h100) begin
         errors++; $display("FAIL exc_info: info=%h pc=%h expected 02/100", bus.trap_info, bus.trap_pc);
      end
      bus.exc_req = 1'b0;
      tick();
      checks++;
      if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h8000 || bus.ctrl_trap !== 1'b0) begin
         errors++; $display("FAIL exc_redirect: valid=%b pc=%h expected 1/8000", bus.redirect_valid, bus.redirect_pc);
      end
      tick();
      checks++;
      if ({bus.pipe_hold, bus.redirect_valid} !== 2'b00) begin
         errors++; $display("FAIL exc_release: hold/valid got %b expected 00", {bus.pipe_hold, bus.redirect_valid});
      end
   endtask

   task automatic test_vectored_irq();
      logic [31:0] exp_pc;
      clear_inputs();
      bus.csr_mie = 1'b1; bus.csr_mie_reg = 32'h880; bus.irq_meip = 1'b1; bus.irq_mtip = 1'b1;
      bus.irq_pc = 32'h204; bus.csr_mtvec = 32'h8001; bus.pipe_drained = 1'b1;
`ifdef TRAP_CTRL_VECTORED_EN
      exp_pc = 32'h802C;
`else
      exp_pc = 32'h8000;
`endif
      tick();
      tick();
      checks++;
      if (bus.ctrl_trap !== 1'b1 || bus.trap_info !== 5'h1B || bus.trap_pc !== 32'h204 || bus.req_ack !== 1'b0) begin
         errors++; $display("FAIL irq_strobe: trap=%b info=%h pc=%h ack=%b expected 1/1b/204/0",
                            bus.ctrl_trap, bus.trap_info, bus.trap_pc, bus.req_ack);
      end
      bus.irq_meip = 1'b0; bus.irq_mtip = 1'b0; bus.csr_mie = 1'b0;
      tick();
      checks++;
      if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== exp_pc) begin
         errors++; $display("FAIL irq_redirect: valid=%b pc=%h expected 1/%h", bus.redirect_valid, bus.redirect_pc, exp_pc);
      end
      tick();
   endtask

   task automatic test_mret_drain();
      int traps, redirs, bad_mret;
      logic [31:0] rpc;
      clear_inputs();
      bus.mret_req = 1'b1; bus.csr_mepc = 32'h340; bus.csr_mtvec = 32'h8000;
      traps = 0; redirs = 0; bad_mret = 0; rpc = '0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if ({bus.pipe_hold, bus.ctrl_trap} !== 2'b10) begin
            errors++; $display("FAIL mret_wait%0d: hold/trap got %b expected 10", i, {bus.pipe_hold, bus.ctrl_trap});
         end
      end
      bus.pipe_drained = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.ctrl_trap === 1'b1) traps++;
         if (bus.ctrl_mret !== bus.ctrl_trap) bad_mret++;
         if (bus.req_ack === 1'b1) bus.mret_req = 1'b0;
         if (bus.redirect_valid === 1'b1) begin redirs++; rpc = bus.redirect_pc; end
      end
      checks++;
      if (traps != 1 || redirs != 1 || bad_mret != 0) begin
         errors++; $display("FAIL mret_pulses: traps=%0d redirs=%0d mret_mismatch=%0d expected 1/1/0", traps, redirs, bad_mret);
      end
      checks++;
      if (rpc !== 32'h340 || bus.pipe_hold !== 1'b0) begin
         errors++; $display("FAIL mret_redirect: pc=%h hold=%b expected 340/0", rpc, bus.pipe_hold);
      end
   endtask

   task automatic test_spurious_abort();
      clear_inputs();
      bus.csr_mie = 1'b1; bus.csr_mie_reg = 32'h80; bus.irq_mtip = 1'b1; bus.irq_pc = 32'h300;
      tick();
      checks++;
      if (bus.pipe_hold !== 1'b1) begin
         errors++; $display("FAIL spur_hold: got %b expected 1", bus.pipe_hold);
      end
      bus.irq_mtip = 1'b0;
      tick();
      bus.pipe_drained = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({bus.pipe_hold, bus.ctrl_trap, bus.redirect_valid} !== 3'b000) begin
            errors++; $display("FAIL spur_quiet%0d: hold/trap/redir got %b expected 000", i,
                               {bus.pipe_hold, bus.ctrl_trap, bus.redirect_valid});
         end
         tick();
      end
   endtask

   task automatic test_exc_replaces_irq();
      clear_inputs();
      bus.csr_mie = 1'b1; bus.csr_mie_reg = 32'h8; bus.irq_msip = 1'b1; bus.irq_pc = 32'h500;
      bus.csr_mtvec = 32'h8001;
      tick();
      bus.exc_req = 1'b1; bus.exc_code = 4'd5; bus.exc_pc = 32'h444;
      tick();
      bus.pipe_drained = 1'b1;
      tick();
      checks++;
      if (bus.ctrl_trap !== 1'b1 || bus.trap_info !== 5'h05 || bus.trap_pc !== 32'h444 || bus.req_ack !== 1'b1) begin
         errors++; $display("FAIL replace_strobe: trap=%b info=%h pc=%h ack=%b expected 1/05/444/1",
                            bus.ctrl_trap, bus.trap_info, bus.trap_pc, bus.req_ack);
      end
      bus.exc_req = 1'b0; bus.irq_msip = 1'b0; bus.csr_mie = 1'b0;
      tick();
      checks++;
      if (bus.redirect_pc !== 32'h8000) begin
         errors++; $display("FAIL replace_redirect: pc=%h expected 8000", bus.redirect_pc);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      logic [73:0] outs;
      clear_inputs();
      bus.exc_req = 1'b1; bus.exc_code = 4'd4; bus.exc_pc = 32'h910; bus.csr_mtvec = 32'hA000;
      tick();
      bus.pipe_drained = 1'b1;
      ctrl_reset = 1'b1;
      tick();
      outs = {bus.req_ack, bus.pipe_hold, bus.ctrl_trap, bus.ctrl_mret, bus.trap_info,
              bus.trap_pc, bus.redirect_valid, bus.redirect_pc};
      checks++;
      if (outs !== '0) begin
         errors++; $display("FAIL midreset_outputs: got %h expected 0", outs);
      end
      ctrl_reset = 1'b0;
      tick();
      checks++;
      if ({bus.pipe_hold, bus.ctrl_trap} !== 2'b10) begin
         errors++; $display("FAIL midreset_restart: hold/trap got %b expected 10", {bus.pipe_hold, bus.ctrl_trap});
      end
      tick();
      checks++;
      if (bus.ctrl_trap !== 1'b1 || bus.trap_info !== 5'h04 || bus.trap_pc !== 32'h910) begin
         errors++; $display("FAIL midreset_strobe: trap=%b info=%h pc=%h expected 1/04/910",
                            bus.ctrl_trap, bus.trap_info, bus.trap_pc);
      end
      bus.exc_req = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_back_to_back();
      clear_inputs();
      bus.exc_req = 1'b1; bus.exc_code = 4'd3; bus.exc_pc = 32'h600;
      bus.mret_req = 1'b1; bus.csr_mepc = 32'h700; bus.csr_mtvec = 32'h9000; bus.pipe_drained = 1'b1;
      tick();
      tick();
      checks++;
      if ({bus.ctrl_trap, bus.ctrl_mret, bus.req_ack} !== 3'b101 || bus.trap_info !== 5'h03) begin
         errors++; $display("FAIL b2b_exc: trap/mret/ack=%b info=%h expected 101/03",
                            {bus.ctrl_trap, bus.ctrl_mret, bus.req_ack}, bus.trap_info);
      end
      bus.exc_req = 1'b0;
      tick();
      checks++;
      if (bus.redirect_pc !== 32'h9000) begin
         errors++; $display("FAIL b2b_exc_redirect: pc=%h expected 9000", bus.redirect_pc);
      end
      tick();
      checks++;
      if (bus.pipe_hold !== 1'b0) begin
         errors++; $display("FAIL b2b_gap: hold=%b expected 0", bus.pipe_hold);
      end
      tick();
      tick();
      checks++;
      if ({bus.ctrl_trap, bus.ctrl_mret, bus.req_ack} !== 3'b111 || bus.trap_info !== 5'h00) begin
         errors++; $display("FAIL b2b_mret: trap/mret/ack=%b info=%h expected 111/00",
                            {bus.ctrl_trap, bus.ctrl_mret, bus.req_ack}, bus.trap_info);
      end
      bus.mret_req = 1'b0;
      tick();
      checks++;
      if (bus.redirect_pc !== 32'h700) begin
         errors++; $display("FAIL b2b_mret_redirect: pc=%h expected 700", bus.redirect_pc);
      end
      tick();
   endtask

   task automatic test_random();
      int unsigned prio[3];
      bit e, m, irq, found, seen;
      int code, d, n, exp_lat;
      logic line;
      logic [31:0] exp_pc, exp_tgt;
      prio[0] = 11; prio[1] = 3; prio[2] = 7;
      for (int it = 0; it < 40; it++) begin
         clear_inputs();
         e = ($urandom_range(0, 3) == 0);
         m = ($urandom_range(0, 3) == 0);
         bus.exc_req = e; bus.mret_req = m;
         bus.exc_code = 4'($urandom); bus.exc_pc = $urandom; bus.irq_pc = $urandom;
         bus.irq_msip = 1'($urandom); bus.irq_mtip = 1'($urandom); bus.irq_meip = 1'($urandom);
         bus.csr_mie = ($urandom_range(0, 3) != 0);
         bus.csr_mie_reg = $urandom; bus.csr_mtvec = $urandom; bus.csr_mepc = $urandom & 32'hFFFF_FFFC;
         d = int'($urandom_range(0, 3));
         // Model: exception, then mret, then first qualified interrupt in priority order
         irq = 1'b0; found = e || m; code = e ? int'(bus.exc_code) : 0;
         exp_pc = e ? bus.exc_pc : 32'h0;
         if (!found) begin
            for (int k = 0; k < 3; k++) begin
               line = (prio[k] == 11) ? bus.irq_meip : (prio[k] == 3) ? bus.irq_msip : bus.irq_mtip;
               if (!found && line && bus.csr_mie && bus.csr_mie_reg[prio[k]]) begin
                  found = 1'b1; irq = 1'b1; code = int'(prio[k]); exp_pc = bus.irq_pc;
               end
            end
         end
         exp_tgt = ref_target(!e && m, irq, code, bus.csr_mtvec, bus.csr_mepc);
         bus.pipe_drained = (d == 0);
         if (!found) begin
            for (int k = 0; k < 4; k++) begin
               tick();
               checks++;
               if ({bus.pipe_hold, bus.ctrl_trap} !== 2'b00) begin
                  errors++; $display("FAIL rand%0d_idle: hold/trap got %b expected 00", it, {bus.pipe_hold, bus.ctrl_trap});
               end
            end
         end else begin
            n = 0; seen = 1'b0;
            exp_lat = (d + 1 > 2) ? d + 1 : 2;
            while (!seen && n < 12) begin
               tick();
               n++;
               if (n >= d) bus.pipe_drained = 1'b1;
               if (bus.ctrl_trap === 1'b1) seen = 1'b1;
            end
            checks++;
            if (!seen || n != exp_lat) begin
               errors++; $display("FAIL rand%0d_latency: seen=%b cycles=%0d expected 1/%0d", it, seen, n, exp_lat);
            end
            checks++;
            if (bus.trap_info !== ((!e && m) ? 5'h00 : {irq, 4'(code)}) ||
                bus.trap_pc !== exp_pc || bus.ctrl_mret !== (!e && m) || bus.req_ack !== !irq) begin
               errors++; $display("FAIL rand%0d_strobe: info=%h pc=%h mret=%b ack=%b expected %h/%h/%b/%b", it,
                                  bus.trap_info, bus.trap_pc, bus.ctrl_mret, bus.req_ack,
                                  (!e && m) ? 5'h00 : {irq, 4'(code)}, exp_pc, !e && m, !irq);
            end
            bus.exc_req = 1'b0; bus.mret_req = 1'b0;
            bus.irq_msip = 1'b0; bus.irq_mtip = 1'b0; bus.irq_meip = 1'b0; bus.csr_mie = 1'b0;
            tick();
            checks++;
            if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== exp_tgt) begin
               errors++; $display("FAIL rand%0d_redirect: valid=%b pc=%h expected 1/%h", it,
                                  bus.redirect_valid, bus.redirect_pc, exp_tgt);
            end
            clear_inputs();
            tick();
            checks++;
            if (bus.pipe_hold !== 1'b0) begin
               errors++; $display("FAIL rand%0d_release: hold=%b expected 0", it, bus.pipe_hold);
            end
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      ctrl_reset = 1'b1;
      clear_inputs();
      test_reset();
      test_exception();
      test_vectored_irq();
      test_mret_drain();
      test_spurious_abort();
      test_exc_replaces_irq();
      test_reset_mid();
      test_back_to_back();
      test_random();
      test_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
